mem_arbiter: RTL and testbench

Two-port arbiter and sequencer sharing one unified memory port between the fetch stage (read-only instruction requests) and the load/store unit (data loads/stores). It serialises requests onto a single-outstanding memory bus, applies round-robin arbitration and a response watchdog, and drives per-port stall signals into the two-stage pipeline's hazard logic.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/rr_arb2.sv | 23 ++
 rtl/mem_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/load-store memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam logic [3:0] DEFAULT_MASK = 4'hF;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick between the data and fetch requesters.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic   d_req,
    input  logic   i_req,
    input  owner_e last_grant,
    output logic   valid,
    output owner_e grant
);

    always_comb begin
        valid = d_req | i_req;
        grant = OWN_I;
        // on a tie the port that did not win last time goes first
        if (d_req && i_req) begin
            grant = (last_grant == OWN_I) ? OWN_D : OWN_I;
        end else if (d_req) begin
            grant = OWN_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and load/store requests onto one single-outstanding memory
// port with round-robin arbitration, a response watchdog and per-port stalls.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_err,
    output logic              i_stall,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_mask,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_mask,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_e            state, state_nxt;
    owner_e            owner, owner_nxt;
    owner_e            last_grant, last_nxt;
    logic [WD_W-1:0]   wd, wd_nxt;
    logic              flush, flush_nxt;

    logic              mem_req_nxt, mem_wr_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt;
    logic [3:0]        mem_mask_nxt;
    logic              i_rvalid_nxt, i_err_nxt, d_rvalid_nxt, d_err_nxt;
    logic [DATA_W-1:0] i_rdata_nxt, d_rdata_nxt;

    logic              arb_valid;
    owner_e            arb_grant;
    logic              drop, flush_eff, timeout, go_resp, resp_err;
    logic [DATA_W-1:0] resp_data;

    rr_arb2 u_rr_arb2 (
        .d_req      (d_req),
        .i_req      (i_req),
        .last_grant (last_grant),
        .valid      (arb_valid),
        .grant      (arb_grant)
    );

    // the fetch owner may withdraw its request; the data owner never does
    assign drop      = (owner == OWN_I) & ~i_req;
    assign flush_eff = flush | drop;
    assign timeout   = (wd == WD_LAST);

    // next-state and next-output logic
    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        last_nxt      = last_grant;
        wd_nxt        = wd;
        flush_nxt     = flush;
        mem_req_nxt   = 1'b0;
        mem_wr_nxt    = mem_wr;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        mem_mask_nxt  = mem_mask;
        i_rvalid_nxt  = 1'b0;
        i_rdata_nxt   = '0;
        i_err_nxt     = 1'b0;
        d_rvalid_nxt  = 1'b0;
        d_rdata_nxt   = '0;
        d_err_nxt     = 1'b0;
        go_resp       = 1'b0;
        resp_err      = 1'b0;
        resp_data     = '0;

        case (state)
            IDLE: begin
                if (arb_valid) begin
                    state_nxt   = REQ;
                    owner_nxt   = arb_grant;
                    wd_nxt      = '0;
                    flush_nxt   = 1'b0;
                    mem_req_nxt = 1'b1;
                    if (arb_grant == OWN_D) begin
                        mem_wr_nxt    = d_wr;
                        mem_addr_nxt  = d_addr;
                        mem_wdata_nxt = d_wdata;
                        mem_mask_nxt  = d_mask;
                    end else begin
                        mem_wr_nxt    = 1'b0;
                        mem_addr_nxt  = i_addr;
                        mem_wdata_nxt = '0;
                        mem_mask_nxt  = DEFAULT_MASK;
                    end
                end
            end
            REQ: begin
                wd_nxt = wd + WD_W'(1);
                if (drop && !mem_gnt) begin
                    state_nxt = IDLE;
                end else if (timeout) begin
                    go_resp  = 1'b1;
                    resp_err = 1'b1;
                end else if (mem_gnt) begin
                    state_nxt = WAIT;
                    flush_nxt = flush_eff;
                end else begin
                    mem_req_nxt = 1'b1;
                end
            end
            WAIT: begin
                wd_nxt    = wd + WD_W'(1);
                flush_nxt = flush_eff;
                if (mem_rvalid) begin
                    go_resp   = 1'b1;
                    resp_data = mem_wr ? '0 : mem_rdata;
                end else if (timeout) begin
                    go_resp  = 1'b1;
                    resp_err = 1'b1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
                last_nxt  = owner;
            end
            default: state_nxt = IDLE;
        endcase

        if (go_resp) begin
            state_nxt = RESP;
            if (owner == OWN_D) begin
                d_rvalid_nxt = 1'b1;
                d_rdata_nxt  = resp_data;
                d_err_nxt    = resp_err;
            end else if (!flush_eff) begin
                i_rvalid_nxt = 1'b1;
                i_rdata_nxt  = resp_data;
                i_err_nxt    = resp_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= OWN_I;
            last_grant <= OWN_I;
            wd         <= '0;
            flush      <= 1'b0;
            mem_req    <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_mask   <= '0;
            i_rvalid   <= 1'b0;
            i_rdata    <= '0;
            i_err      <= 1'b0;
            d_rvalid   <= 1'b0;
            d_rdata    <= '0;
            d_err      <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_grant <= last_nxt;
            wd         <= wd_nxt;
            flush      <= flush_nxt;
            mem_req    <= mem_req_nxt;
            mem_wr     <= mem_wr_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            mem_mask   <= mem_mask_nxt;
            i_rvalid   <= i_rvalid_nxt;
            i_rdata    <= i_rdata_nxt;
            i_err      <= i_err_nxt;
            d_rvalid   <= d_rvalid_nxt;
            d_rdata    <= d_rdata_nxt;
            d_err      <= d_err_nxt;
        end
    end

    assign i_stall = i_req & ~((state == RESP) & (owner == OWN_I) & i_rvalid);
    assign d_stall = d_req & ~((state == RESP) & (owner == OWN_D) & d_rvalid);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;

    localparam int unsigned TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_rvalid, i_err, i_stall;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_wr, d_rvalid, d_err, d_stall;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_mask;
    logic        mem_req, mem_wr, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_mask;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .i_err(i_err), .i_stall(i_stall),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_mask(d_mask),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err), .d_stall(d_stall),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_mask(mem_mask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Transaction-level model: one transaction at a time, aged in cycles.
    bit          m_live = 0, m_busy, m_resp, m_own_d, m_acc, m_drop, m_pref_d;
    int          m_age;
    logic        e_mreq, e_mwr, e_irv, e_ierr, e_drv, e_derr;
    logic [31:0] e_maddr, e_mwdata, e_ird, e_drd;
    logic [3:0]  e_mmask;

    function automatic void m_finish(input bit err);
        logic [31:0] data;
        data   = (err || e_mwr) ? 32'h0 : mem_rdata;
        m_busy = 0;
        m_resp = 1;
        e_mreq = 0;
        if (m_own_d) begin
            e_drv = 1; e_drd = data; e_derr = err;
        end else if (!m_drop) begin
            e_irv = 1; e_ird = data; e_ierr = err;
        end
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_live = 1; m_busy = 0; m_resp = 0; m_pref_d = 1;
            e_mreq = 0; e_mwr = 0; e_maddr = 0; e_mwdata = 0; e_mmask = 0;
            e_irv = 0; e_ierr = 0; e_ird = 0; e_drv = 0; e_derr = 0; e_drd = 0;
        end else if (m_live) begin
            bit lost;
            e_irv = 0;
            e_drv = 0;
            lost  = !m_own_d && !i_req;
            if (m_resp) begin
                m_resp   = 0;
                m_pref_d = !m_own_d;
            end else if (m_busy) begin
                m_age++;
                if (!m_acc) begin
                    if (lost && !mem_gnt) begin
                        m_busy = 0; e_mreq = 0;
                    end else if (m_age == TIMEOUT) begin
                        m_drop = m_drop | lost; m_finish(1);
                    end else if (mem_gnt) begin
                        m_acc = 1; e_mreq = 0; m_drop = m_drop | lost;
                    end
                end else begin
                    m_drop = m_drop | lost;
                    if (mem_rvalid) m_finish(0);
                    else if (m_age == TIMEOUT) m_finish(1);
                end
            end else if (i_req || d_req) begin
                m_own_d = d_req && (!i_req || m_pref_d);
                m_busy = 1; m_acc = 0; m_drop = 0; m_age = 0; e_mreq = 1;
                if (m_own_d) begin
                    e_mwr = d_wr; e_maddr = d_addr; e_mwdata = d_wdata; e_mmask = d_mask;
                end else begin
                    e_mwr = 0; e_maddr = i_addr; e_mwdata = 0; e_mmask = 4'hF;
                end
            end
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (m_live) begin
            cmp("mem_req", 32'(mem_req), 32'(e_mreq));
            if (e_mreq) begin
                cmp("mem_wr", 32'(mem_wr), 32'(e_mwr));
                cmp("mem_addr", mem_addr, e_maddr);
                cmp("mem_wdata", mem_wdata, e_mwdata);
                cmp("mem_mask", 32'(mem_mask), 32'(e_mmask));
            end
            cmp("i_rvalid", 32'(i_rvalid), 32'(e_irv));
            cmp("d_rvalid", 32'(d_rvalid), 32'(e_drv));
            if (e_irv) begin
                cmp("i_rdata", i_rdata, e_ird);
                cmp("i_err", 32'(i_err), 32'(e_ierr));
            end
            if (e_drv) begin
                cmp("d_rdata", d_rdata, e_drd);
                cmp("d_err", 32'(d_err), 32'(e_derr));
            end
            cmp("i_stall", 32'(i_stall), 32'(i_req && !e_irv));
            cmp("d_stall", 32'(d_stall), 32'(d_req && !e_drv));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 0; i_req = 0; d_req = 0; mem_gnt = 0; mem_rvalid = 0;
        tick(); tick();
        rst = 1;
    endtask

    // memory side of one granted transaction; returns in the response cycle
    task automatic serve(input int gdly, input int rdly, input logic [31:0] data);
        for (int k = 0; k < gdly; k++) begin
            mem_gnt = 0;
            tick();
            cmp("req_held", 32'(mem_req), 32'd1);
        end
        mem_gnt = 1;
        tick();
        mem_gnt = 0;
        for (int k = 0; k < rdly; k++) tick();
        mem_rvalid = 1;
        mem_rdata  = data;
        tick();
        mem_rvalid = 0;
    endtask

    bit prev_i_rv, prev_d_rv;

    initial begin
        rst = 0; i_req = 0; i_addr = 0; d_req = 0; d_wr = 0; d_addr = 0; d_wdata = 0;
        d_mask = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        do_reset();
        cmp("rst_mask", 32'(mem_mask), 32'd0);
        cmp("rst_irdata", i_rdata, 32'd0);

        // lone fetch, minimum latency
        i_req = 1; i_addr = 32'h100;
        #1 cmp("stall_n", 32'(i_stall), 32'd1);
        tick();
        cmp("f_addr", mem_addr, 32'h100);
        cmp("f_mask", 32'(mem_mask), 32'hF);
        serve(0, 0, 32'h0050_0093);
        cmp("f_rv", 32'(i_rvalid), 32'd1);
        cmp("f_data", i_rdata, 32'h0050_0093);
        cmp("f_stall", 32'(i_stall), 32'd0);
        i_req = 0;
        tick();

        // tie after reset: data first, then fetch, then data again
        do_reset();
        d_req = 1; d_wr = 1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_mask = 4'b0011;
        i_req = 1; i_addr = 32'h104;
        tick();
        cmp("t_wr", 32'(mem_wr), 32'd1);
        cmp("t_addr", mem_addr, 32'h200);
        cmp("t_wdata", mem_wdata, 32'hDEAD_BEEF);
        cmp("t_mask", 32'(mem_mask), 32'h3);
        serve(0, 0, 32'h5555_5555);
        cmp("t_drv", 32'(d_rvalid), 32'd1);
        cmp("t_store_rd", d_rdata, 32'h0);
        d_req = 0;
        tick(); tick();
        cmp("t2_addr", mem_addr, 32'h104);
        serve(3, 0, 32'h1234_5678);
        cmp("t2_data", i_rdata, 32'h1234_5678);
        d_req = 1; d_wr = 0; d_addr = 32'h300; i_addr = 32'h108;
        tick(); tick();
        cmp("t3_addr", mem_addr, 32'h300);
        serve(0, 1, 32'hCAFE_0001);
        cmp("t3_data", d_rdata, 32'hCAFE_0001);
        d_req = 0;
        tick(); tick();
        cmp("t4_addr", mem_addr, 32'h108);
        serve(0, 0, 32'h0);
        i_req = 0;
        tick();

        // watchdog: granted load never answered
        d_req = 1; d_wr = 0; d_addr = 32'h400;
        tick();
        mem_gnt = 1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            mem_gnt = 0;
            if (k == 7) cmp("wd_early", 32'(d_rvalid), 32'd0);
        end
        cmp("wd_rv", 32'(d_rvalid), 32'd1);
        cmp("wd_err", 32'(d_err), 32'd1);
        cmp("wd_rd", d_rdata, 32'h0);
        d_req = 0; mem_rvalid = 1;
        tick(); tick();
        mem_rvalid = 0;
        cmp("wd_late", 32'(d_rvalid), 32'd0);

        // fetch abandoned before grant, then during wait
        i_req = 1; i_addr = 32'h120;
        tick();
        i_req = 0;
        tick();
        cmp("ab_req", 32'(mem_req), 32'd0);
        i_req = 1; i_addr = 32'h124;
        tick();
        mem_gnt = 1;
        tick();
        mem_gnt = 0; i_req = 0; mem_rvalid = 1; mem_rdata = 32'h7777_7777;
        tick();
        mem_rvalid = 0;
        cmp("fl_rv", 32'(i_rvalid), 32'd0);
        tick();

        // reset while waiting, then a clean fetch
        i_req = 1; i_addr = 32'h130;
        tick();
        mem_gnt = 1;
        tick();
        mem_gnt = 0; rst = 0; i_req = 0;
        tick();
        cmp("mr_req", 32'(mem_req), 32'd0);
        cmp("mr_mask", 32'(mem_mask), 32'd0);
        rst = 1; i_req = 1; i_addr = 32'h140;
        tick();
        serve(0, 0, 32'hA5A5_0000);
        cmp("mr_data", i_rdata, 32'hA5A5_0000);
        i_req = 0;
        tick();

        // randomized traffic
        prev_i_rv = 0; prev_d_rv = 0;
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 499) != 0);
            if (i_req) begin
                if (prev_i_rv || $urandom_range(0, 99) < 4) i_req = 0;
            end else if ($urandom_range(0, 99) < 30) begin
                i_req = 1; i_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (d_req) begin
                if (prev_d_rv) d_req = 0;
            end else if ($urandom_range(0, 99) < 25) begin
                d_req = 1; d_wr = 1'($urandom); d_addr = $urandom; d_wdata = $urandom;
                d_mask = 4'($urandom);
            end
            prev_i_rv  = i_rvalid;
            prev_d_rv  = d_rvalid;
            mem_gnt    = 1'($urandom);
            mem_rvalid = ($urandom_range(0, 99) < 35);
            mem_rdata  = $urandom;
            tick();
        end
        rst = 1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
